// File: rtl/ensemble_pkg.sv
// rtl/ensemble_pkg.sv - shared constants for the ensemble majority voter
package ensemble_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int KEEP_WIDTH_DEF = 4;

  localparam logic [1:0] AGREE_ALL = 2'd3;
  localparam logic [1:0] AGREE_MAJ = 2'd2;
  localparam logic [1:0] AGREE_TIE = 2'd1;

  localparam int AGREE_LSB = 16;
  localparam int AGREE_MSB = 17;
endpackage

// File: rtl/axis_hold_reg.sv
// rtl/axis_hold_reg.sv - one-entry lane buffer with full flag, registered ready and clear
module axis_hold_reg #(
  parameter int LABEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic [LABEL_WIDTH-1:0] label_i,
  input  logic                   last_i,
  input  logic                   clear_i,
  output logic                   ready_o,
  output logic                   full_o,
  output logic [LABEL_WIDTH-1:0] label_o,
  output logic                   last_o
);
  logic                   full_q, full_d;
  logic                   ready_q;
  logic [LABEL_WIDTH-1:0] label_q;
  logic                   last_q;
  logic                   accept;

  assign accept = valid_i && ready_q;
  assign full_d = accept || (full_q && !clear_i);

  // ready is a flop of !full_d so it stays low through reset and rises one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      label_q <= '0;
      last_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
      if (accept) begin
        label_q <= label_i;
        last_q  <= last_i;
      end
    end
  end

  assign ready_o = ready_q;
  assign full_o  = full_q;
  assign label_o = label_q;
  assign last_o  = last_q;
endmodule

// File: rtl/ensemble_voter.sv
// rtl/ensemble_voter.sv - three-lane AXI-Stream majority voter
// Optional statistics counters enabled by ENSEMBLE_VOTER_STATS_EN.
module ensemble_voter
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int KEEP_WIDTH  = KEEP_WIDTH_DEF,
  parameter int CLASS_WIDTH = 8,
  parameter int TIE_LANE    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  input  logic                  s_axis_tlast_1,
  output logic                  s_axis_tready_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  input  logic                  s_axis_tlast_2,
  output logic                  s_axis_tready_2,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_3,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_3,
  input  logic                  s_axis_tvalid_3,
  input  logic                  s_axis_tlast_3,
  output logic                  s_axis_tready_3,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  tlast_err,
  output logic [31:0]           sample_count,
  output logic [31:0]           disagree_count
);
  logic [2:0]             full;
  logic [2:0]             held_last;
  logic [CLASS_WIDTH-1:0] la, lb, lc;
  logic                   vote_fire;
  logic [CLASS_WIDTH-1:0] vote_label;
  logic [1:0]             vote_code;
  logic [DATA_WIDTH-1:0]  vote_data;

  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_last_q;
  logic                  err_q;

  axis_hold_reg #(.LABEL_WIDTH(CLASS_WIDTH)) u_lane1 (
    .clk(clk), .rst_n(rst_n), .valid_i(s_axis_tvalid_1),
    .label_i(s_axis_tdata_1[CLASS_WIDTH-1:0]), .last_i(s_axis_tlast_1),
    .clear_i(vote_fire), .ready_o(s_axis_tready_1), .full_o(full[0]),
    .label_o(la), .last_o(held_last[0])
  );
  axis_hold_reg #(.LABEL_WIDTH(CLASS_WIDTH)) u_lane2 (
    .clk(clk), .rst_n(rst_n), .valid_i(s_axis_tvalid_2),
    .label_i(s_axis_tdata_2[CLASS_WIDTH-1:0]), .last_i(s_axis_tlast_2),
    .clear_i(vote_fire), .ready_o(s_axis_tready_2), .full_o(full[1]),
    .label_o(lb), .last_o(held_last[1])
  );
  axis_hold_reg #(.LABEL_WIDTH(CLASS_WIDTH)) u_lane3 (
    .clk(clk), .rst_n(rst_n), .valid_i(s_axis_tvalid_3),
    .label_i(s_axis_tdata_3[CLASS_WIDTH-1:0]), .last_i(s_axis_tlast_3),
    .clear_i(vote_fire), .ready_o(s_axis_tready_3), .full_o(full[2]),
    .label_o(lc), .last_o(held_last[2])
  );

  // input keep and upper data bits carry nothing the vote needs
  logic unused_inputs;
  assign unused_inputs = &{1'b0, s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3,
                           s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3};

  assign vote_fire = (&full) && (!m_valid_q || m_axis_tready);

  always_comb begin
    vote_label = la;
    vote_code  = AGREE_TIE;
    if (la == lb && lb == lc) begin
      vote_code = AGREE_ALL;
    end else if (la == lb || la == lc) begin
      vote_code = AGREE_MAJ;
    end else if (lb == lc) begin
      vote_label = lb;
      vote_code  = AGREE_MAJ;
    end else begin
      case (TIE_LANE)
        1:       vote_label = la;
        2:       vote_label = lb;
        default: vote_label = lc;
      endcase
    end
    vote_data = '0;
    vote_data[CLASS_WIDTH-1:0]      = vote_label;
    vote_data[AGREE_MSB:AGREE_LSB]  = vote_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (vote_fire) begin
      m_valid_q <= 1'b1;
      m_data_q  <= vote_data;
      m_last_q  <= |held_last;
      if (!(&held_last) && (|held_last)) err_q <= 1'b1;
    end else if (m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tkeep  = {KEEP_WIDTH{m_valid_q}};
  assign tlast_err     = err_q;

`ifdef ENSEMBLE_VOTER_STATS_EN
  logic [31:0] sample_q, disagree_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q   <= '0;
      disagree_q <= '0;
    end else if (m_valid_q && m_axis_tready) begin
      sample_q <= sample_q + 32'd1;
      if (m_data_q[AGREE_MSB:AGREE_LSB] != AGREE_ALL) disagree_q <= disagree_q + 32'd1;
    end
  end
  assign sample_count   = sample_q;
  assign disagree_count = disagree_q;
`else
  assign sample_count   = 32'd0;
  assign disagree_count = 32'd0;
`endif
endmodule
